// File: rtl/drive_cmd_pkg.sv
// Shared types for the drive command arbiter: command codes, command
// sources, arbiter FSM states and the camera-direction mapping.
package drive_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_STOP  = 4'd0,
        CMD_FWD   = 4'd1,
        CMD_LEFT  = 4'd2,
        CMD_RIGHT = 4'd3,
        CMD_REV   = 4'd4
    } cmd_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_IR     = 2'd1,
        SRC_CAM    = 2'd2,
        SRC_SAFETY = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Highest legal IR code; anything above is ignored at capture.
    localparam logic [3:0] CMD_CODE_MAX = CMD_REV;

    // Camera direction 1..3 is a steering request; other values are not.
    function automatic logic cam_dir_is_request(input logic [2:0] dir);
        return dir inside {3'd1, 3'd2, 3'd3};
    endfunction

    function automatic cmd_t cam_to_cmd(input logic [2:0] dir);
        case (dir)
            3'd1:    return CMD_LEFT;
            3'd2:    return CMD_FWD;
            3'd3:    return CMD_RIGHT;
            default: return CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating down-counter: load sets it to LOAD_VAL, each tick decrements,
// it holds at zero and never wraps. zero is high while the count is 0.
module cycle_timer #(
    parameter int unsigned LOAD_VAL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic zero
);

    localparam int unsigned WIDTH = $clog2(LOAD_VAL) + 1;
    localparam logic [WIDTH-1:0] LOAD_W = WIDTH'(LOAD_VAL);

    logic [WIDTH-1:0] count;

    // Load wins over tick; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_W;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Merges IR remote, camera classifier and e-stop into one handshaked
// command stream with priority, minimum gap, manual-override hold,
// duplicate suppression for camera commands and a no-command watchdog.
module drive_cmd_arbiter
    import drive_cmd_pkg::*;
#(
    parameter int unsigned MIN_GAP     = 5_000_000,
    parameter int unsigned WATCHDOG    = 50_000_000,
    parameter int unsigned MANUAL_HOLD = 150_000_000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       ir_valid,
    input  logic [3:0] ir_cmd,
    input  logic       cam_valid,
    input  logic [2:0] cam_dir,
    input  logic       estop,
    output logic       cmd_valid,
    output logic [3:0] cmd_data,
    input  logic       cmd_ready,
    output logic [1:0] active_src,
    output logic       manual_mode,
    output logic       watchdog_trip
);

    // The gap timer is loaded one short so that GAP lasts MIN_GAP cycles,
    // and exactly one cycle when MIN_GAP is 0 or 1.
    localparam int unsigned GAP_LOAD = (MIN_GAP > 1) ? MIN_GAP - 1 : 0;

    state_t state;
    cmd_t   cmd_q;
    src_t   src_q;
    logic   wd_cause_q;      // offered STOP was raised by the watchdog
    logic   pend_valid;
    logic   pend_sent;       // pending IR code is the one currently offered
    cmd_t   pend_cmd;
    cmd_t   last_sent;
    src_t   active_src_q;
    logic   wd_expired;
    logic   gap_zero;
    logic   wd_zero;
    logic   manual_zero;

    logic   handshake;
    logic   ir_capture;
    logic   sel_hit;
    cmd_t   sel_cmd;
    src_t   sel_src;
    logic   sel_wd;

    assign handshake   = cmd_valid && cmd_ready;
    assign ir_capture  = ir_valid && (ir_cmd <= CMD_CODE_MAX);
    assign cmd_data    = cmd_q;
    assign active_src  = active_src_q;
    assign manual_mode = !manual_zero;

    cycle_timer #(.LOAD_VAL(GAP_LOAD)) u_gap_timer (
        .clk   (clk_50),
        .rst_n (rst_n),
        .load  (handshake),
        .tick  (state == ST_GAP),
        .zero  (gap_zero)
    );

    cycle_timer #(.LOAD_VAL(WATCHDOG)) u_wd_timer (
        .clk   (clk_50),
        .rst_n (rst_n),
        .load  (handshake),
        .tick  (last_sent != CMD_STOP),
        .zero  (wd_zero)
    );

    cycle_timer #(.LOAD_VAL(MANUAL_HOLD)) u_manual_timer (
        .clk   (clk_50),
        .rst_n (rst_n),
        .load  (handshake && src_q == SRC_IR),
        .tick  (1'b1),
        .zero  (manual_zero)
    );

    // Priority selection of the next command; first match wins.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        sel_hit = 1'b0;
        sel_cmd = CMD_STOP;
        sel_src = SRC_NONE;
        sel_wd  = 1'b0;
        if (estop) begin
            sel_hit = 1'b1;
            sel_src = SRC_SAFETY;
        end else if (pend_valid && !pend_sent) begin
            sel_hit = 1'b1;
            sel_cmd = pend_cmd;
            sel_src = SRC_IR;
        end else if (wd_expired && last_sent != CMD_STOP) begin
            sel_hit = 1'b1;
            sel_src = SRC_SAFETY;
            sel_wd  = 1'b1;
        end else if (!manual_mode && cam_valid && cam_dir_is_request(cam_dir) &&
                     cam_to_cmd(cam_dir) != last_sent) begin
            sel_hit = 1'b1;
            sel_cmd = cam_to_cmd(cam_dir);
            sel_src = SRC_CAM;
        end
    end

    // IDLE -> SEND -> GAP sequencing with the registered offer outputs.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_valid  <= 1'b0;
            cmd_q      <= CMD_STOP;
            src_q      <= SRC_NONE;
            wd_cause_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_hit) begin
                        cmd_q      <= sel_cmd;
                        src_q      <= sel_src;
                        wd_cause_q <= sel_wd;
                        cmd_valid  <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (estop || gap_zero) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One-deep IR holding register; a newer pulse always replaces an unsent code.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_sent  <= 1'b0;
            pend_cmd   <= CMD_STOP;
        end else if (ir_capture) begin
            pend_valid <= 1'b1;
            pend_sent  <= 1'b0;
            pend_cmd   <= cmd_t'(ir_cmd);
        end else if (state == ST_IDLE && sel_hit && sel_src == SRC_IR) begin
            pend_sent <= 1'b1;
        end else if (handshake && pend_sent) begin
            pend_valid <= 1'b0;
            pend_sent  <= 1'b0;
        end
    end

    // Post-transfer status: last command, its source, watchdog expiry and trip flag.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            last_sent     <= CMD_STOP;
            active_src_q  <= SRC_NONE;
            wd_expired    <= 1'b0;
            watchdog_trip <= 1'b0;
        end else if (handshake) begin
            last_sent    <= cmd_q;
            active_src_q <= src_q;
            wd_expired   <= 1'b0;
            if (wd_cause_q) begin
                watchdog_trip <= 1'b1;
            end else if (cmd_q != CMD_STOP) begin
                watchdog_trip <= 1'b0;
            end
        end else if (last_sent != CMD_STOP && wd_zero) begin
            wd_expired <= 1'b1;
        end
    end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Randomised self-checking bench for drive_cmd_arbiter. A timestamp-based
// reference model predicts each offered command into a scoreboard queue; a
// monitor pops it on every DUT handshake and also tracks status outputs.
module tb_drive_cmd_arbiter;

    localparam int G  = 4;
    localparam int WD = 40;
    localparam int MH = 20;

    logic       clk_50    = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ir_valid  = 1'b0;
    logic [3:0] ir_cmd    = 4'd0;
    logic       cam_valid = 1'b0;
    logic [2:0] cam_dir   = 3'd0;
    logic       estop     = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [3:0] cmd_data;
    logic [1:0] active_src;
    logic       manual_mode;
    logic       watchdog_trip;

    always #5 clk_50 = ~clk_50;

    drive_cmd_arbiter #(.MIN_GAP(G), .WATCHDOG(WD), .MANUAL_HOLD(MH)) dut (
        .clk_50        (clk_50),
        .rst_n         (rst_n),
        .ir_valid      (ir_valid),
        .ir_cmd        (ir_cmd),
        .cam_valid     (cam_valid),
        .cam_dir       (cam_dir),
        .estop         (estop),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .active_src    (active_src),
        .manual_mode   (manual_mode),
        .watchdog_trip (watchdog_trip)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cmd;
        int src;
    } exp_t;

    exp_t sb[$];
    int   cam_map [4] = '{0, 2, 1, 3};   // dir 1 LEFT, 2 FWD, 3 RIGHT

    int k;            // posedges since reset release
    int m_offer;      // a command is on offer
    int m_cmd, m_src, m_wd;
    int m_last;       // last transferred code
    int m_src_out;    // source of last transferred code
    int m_trip;
    int m_last_hs;    // edge of last transfer
    int m_ir_hs;      // edge of last IR transfer
    int ready_edge;   // first edge at which a new decision may be taken
    int m_pend, m_pend_cmd;
    int expired, in_manual;
    exp_t e_new;

    task automatic model_offer(input int c, input int s, input int w);
        m_offer = 1; m_cmd = c; m_src = s; m_wd = w;
        e_new.cmd = c; e_new.src = s;
        sb.push_back(e_new);
    endtask

    always @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_offer = 0; m_cmd = 0; m_src = 0; m_wd = 0;
            m_last = 0; m_src_out = 0; m_trip = 0;
            m_last_hs = -1000000; m_ir_hs = -1000000; ready_edge = 0;
            m_pend = 0; m_pend_cmd = 0;
            sb.delete();
        end else begin
            k++;
            if (m_offer != 0) begin
                if (cmd_ready) begin
                    m_offer = 0;
                    m_last = m_cmd;
                    m_src_out = m_src;
                    m_last_hs = k;
                    ready_edge = k + ((G > 1) ? G : 1) + 1;
                    if (m_src == 1) m_ir_hs = k;
                    if (m_wd != 0) m_trip = 1;
                    else if (m_cmd != 0) m_trip = 0;
                end
            end else if (k >= ready_edge) begin
                expired   = (m_last != 0 && k >= m_last_hs + WD + 2) ? 1 : 0;
                in_manual = (k <= m_ir_hs + MH) ? 1 : 0;
                if (estop) model_offer(0, 3, 0);
                else if (m_pend != 0) begin
                    model_offer(m_pend_cmd, 1, 0);
                    m_pend = 0;
                end else if (expired != 0) model_offer(0, 3, 1);
                else if (in_manual == 0 && cam_valid && cam_dir >= 1 && cam_dir <= 3 &&
                         cam_map[cam_dir] != m_last)
                    model_offer(cam_map[cam_dir], 2, 0);
            end else if (estop && k < ready_edge - 1) begin
                ready_edge = k + 1;
            end
            if (ir_valid && ir_cmd <= 4) begin
                m_pend = 1;
                m_pend_cmd = int'(ir_cmd);
            end
        end
    end

    // ---------------- monitor ----------------
    exp_t e_pop;
    int   src_due = 0, exp_src = 0;
    int   trip_seen = 0, manual_seen = 0, cam_in_manual = 0, estop_stop_cnt = 0;
    int   watch_left = 0, left_seen = 0, rev_seen = 0;

    always @(negedge clk_50) begin
        if (!rst_n) begin
            src_due = 0;
        end else begin
            if (src_due != 0) begin
                check("src_after_handshake", int'(active_src), exp_src);
                src_due = 0;
            end
            check("cmd_valid", int'(cmd_valid), m_offer);
            if (m_offer != 0 && cmd_valid) check("cmd_data_held", int'(cmd_data), m_cmd);
            check("manual_mode", int'(manual_mode), (k >= m_ir_hs && k < m_ir_hs + MH) ? 1 : 0);
            check("watchdog_trip", int'(watchdog_trip), m_trip);
            check("active_src", int'(active_src), m_src_out);
            if (watchdog_trip) trip_seen = 1;
            if (manual_mode) manual_seen = 1;
            if (cmd_valid && cmd_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer: actual cmd=%0d required none (t=%0t)", cmd_data, $time);
                end else begin
                    e_pop = sb.pop_front();
                    check("transfer_cmd", int'(cmd_data), e_pop.cmd);
                    exp_src = e_pop.src;
                    src_due = 1;
                    if (e_pop.src == 2 && manual_mode) cam_in_manual++;
                    if (e_pop.src == 3 && e_pop.cmd == 0) estop_stop_cnt++;
                    if (watch_left != 0 && cmd_data == 4'd2) left_seen++;
                    if (watch_left != 0 && cmd_data == 4'd4) rev_seen++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic ir_pulse(input logic [3:0] code);
        ir_valid = 1'b1;
        ir_cmd   = code;
        tick();
        ir_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!cmd_valid && n < budget) begin
            tick();
            n++;
        end
        if (!cmd_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: cmd_valid still 0 after %0d cycles, required 1", name, budget);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check("reset_cmd_valid", int'(cmd_valid), 0);
        check("reset_cmd_data", int'(cmd_data), 0);
        check("reset_active_src", int'(active_src), 0);
        check("reset_manual_mode", int'(manual_mode), 0);
        check("reset_watchdog_trip", int'(watchdog_trip), 0);
        rst_n = 1'b1;

        // Idle inputs: nothing may be offered
        tick(100);
        check("idle_active_src", int'(active_src), 0);

        // Camera FWD held long enough for the watchdog to fire
        cam_valid = 1'b1;
        cam_dir   = 3'd2;
        tick(200);
        check("watchdog_trip_seen", trip_seen, 1);

        // IR RIGHT overrides camera and starts the manual hold
        ir_pulse(4'd3);
        tick(40);
        check("manual_mode_seen", manual_seen, 1);
        check("cam_during_manual", cam_in_manual, 0);

        // estop raised while an offer is stalled
        cam_valid = 1'b0;
        cmd_ready = 1'b0;
        ir_pulse(4'd1);
        wait_valid(60, "stall_offer");
        estop = 1'b1;
        tick(10);
        cmd_ready = 1'b1;
        tick(20);
        estop = 1'b0;
        check("estop_stop_sent", (estop_stop_cnt > 0) ? 1 : 0, 1);

        // Two IR pulses inside the gap: only the newer one is sent
        tick(60);
        ir_pulse(4'd1);
        wait_valid(20, "gap_setup_offer");
        tick();                 // handshake edge; now inside GAP
        watch_left = 1;
        ir_pulse(4'd2);
        ir_pulse(4'd4);
        tick(20);
        watch_left = 0;
        check("left_never_sent", left_seen, 0);
        check("rev_sent_once", rev_seen, 1);

        // Reset while an offer is outstanding
        tick(60);
        cmd_ready = 1'b0;
        ir_pulse(4'd3);
        wait_valid(20, "pre_reset_offer");
        #1 rst_n = 1'b0;
        #1 check("reset_drops_valid", int'(cmd_valid), 0);
        tick(2);
        cmd_ready = 1'b1;
        rst_n = 1'b1;
        tick(30);
        check("post_reset_idle_src", int'(active_src), 0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) estop = ~estop;
            if ($urandom_range(0, 99) < 3) cam_valid = ~cam_valid;
            if ($urandom_range(0, 99) < 6) cam_dir = 3'($urandom_range(0, 7));
            cmd_ready = ($urandom_range(0, 3) != 0);
            ir_valid  = ($urandom_range(0, 99) < 2);
            ir_cmd    = 4'($urandom_range(0, 15));
            tick();
        end

        // Drain with idle inputs
        ir_valid  = 1'b0;
        estop     = 1'b0;
        cam_valid = 1'b0;
        cmd_ready = 1'b1;
        tick(150);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
